// File: rtl/sha256_compress.sv
// SHA-256 / SHA-224 block compression with valid/ready handshakes on both sides.
// Optional build macro SHA256_UNROLL2_EN runs two rounds per cycle (32-cycle block instead of 64).
//
// state | meaning
// IDLE  | waiting for a block, in_ready_o=1
// BUSY  | applying rounds t (and t+1 when unrolled) each cycle
// DONE  | h_o valid, waiting for out_ready_i
module sha256_compress #(
   parameter int SHA224 = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic         init_i,
   input  logic [255:0] h_i,
   input  logic [511:0] m_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [255:0] h_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [255:0] IV256 = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   localparam logic [255:0] IV224 = {
      32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
      32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
   localparam logic [255:0] IV = (SHA224 != 0) ? IV224 : IV256;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

`ifdef SHA256_UNROLL2_EN
   localparam logic [5:0] T_STEP = 6'd2;
   localparam logic [5:0] T_LAST = 6'd62;
`else
   localparam logic [5:0] T_STEP = 6'd1;
   localparam logic [5:0] T_LAST = 6'd63;
`endif

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // One SHA-256 round on packed state (a in [31:0] .. h in [255:224]).
   function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] w,
                                            input logic [31:0] k);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      a = s[31:0];    b = s[63:32];   c = s[95:64];   d = s[127:96];
      e = s[159:128]; f = s[191:160]; g = s[223:192]; h = s[255:224];
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {g, f, e, d + t1, c, b, a, t1 + t2};
   endfunction

   // Window holds W[t..t+15]; W[t+16] enters at the top as W[t] leaves the bottom.
   function automatic logic [511:0] sched_f(input logic [511:0] w);
      logic [31:0] w1, w14, nw;
      w1  = w[63:32];
      w14 = w[479:448];
      nw  = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w[319:288]
          + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w[31:0];
      return {nw, w[511:32]};
   endfunction

   state_t         state_q, state_d;
   logic [255:0]   s_q, c_q, h_q;
   logic [511:0]   w_q;
   logic [5:0]     t_q;
   logic [255:0]   s_1, s_nx, h_sum;
   logic [511:0]   w_1, w_nx;
   logic           last_round;

   always_comb begin
      s_1 = round_f(s_q, w_q[31:0], K[t_q]);
      w_1 = sched_f(w_q);
`ifdef SHA256_UNROLL2_EN
      s_nx = round_f(s_1, w_1[31:0], K[t_q + 6'd1]);
      w_nx = sched_f(w_1);
`else
      s_nx = s_1;
      w_nx = w_1;
`endif
      h_sum = '0;
      for (int i = 0; i < 8; i++)
         h_sum[32*i +: 32] = c_q[32*i +: 32] + s_nx[32*i +: 32];
   end

   assign last_round = (t_q == T_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) state_d = BUSY;
         end
         BUSY: if (last_round) state_d = DONE;
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
         c_q <= '0;
         w_q <= '0;
         t_q <= '0;
         h_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid_i) begin
               s_q <= init_i ? IV : h_i;
               c_q <= init_i ? IV : h_i;
               w_q <= m_i;
               t_q <= '0;
            end
            BUSY: begin
               s_q <= s_nx;
               w_q <= w_nx;
               t_q <= t_q + T_STEP;
               if (last_round) h_q <= h_sum;
            end
            default: ;
         endcase
      end
   end

   assign h_o = h_q;

endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 SHALL have parameter SHA224, default 0, meaning: 1 = init_i loads the SHA-224 IV, 0 = init_i loads the SHA-256 IV.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid_i, input, 1, a block is offered.
REQ-005 SHALL have port in_ready_o, output, 1, the block can accept a new input.
REQ-006 SHALL have port init_i, input, 1, use the IV instead of h_i; sampled with the input handshake.
REQ-007 SHALL have port h_i, input, 256, chaining value; word a in [31:0] through word h in [255:224].
REQ-008 SHALL have port m_i, input, 512, message block; W0 in [31:0] through W15 in [511:480].
REQ-009 SHALL have port out_valid_o, output, 1, the result is available.
REQ-010 SHALL have port out_ready_i, input, 1, the consumer takes the result.
REQ-011 SHALL have port h_o, output, 256, chained result; same word packing as h_i.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; in_ready_o = (state==IDLE) and out_valid_o = (state==DONE).
REQ-013 SHALL accept the input when in_valid_i && in_ready_o at a rising edge. At that edge it loads state S and chain C with the IV (if init_i) or h_i, loads schedule W with m_i, sets round counter t=0 and enters BUSY.
REQ-014 SHALL, in each BUSY cycle, apply the standard SHA-256 round to S and W for round index t: combinational round instance, no chaining add, and shift-register message schedule (new word enters at [511:480]).
REQ-015 SHALL increment t by the rounds-per-cycle count; t is 6 bits.
REQ-016 SHALL, on the edge that applies round 63, register h_o = C + S' word-wise mod 2^32 and enter DONE.
REQ-017 SHALL assert out_valid_o exactly 64 cycles after the accept edge (32 cycles with SHA256_UNROLL2_EN).
REQ-018 SHALL hold h_o stable from entry into DONE until the next DONE entry; inputs changing during BUSY or DONE have no effect.
REQ-019 SHALL, in DONE with out_ready_i=1, return to IDLE on that edge; in_ready_o rises the following cycle, and an accept in the same cycle as the output handshake is not possible.
REQ-020 SHALL stay in DONE indefinitely while out_ready_i=0 (back-pressure) and hold S, W and t.
REQ-021 SHALL ignore in_valid_i outside IDLE; out_ready_i outside DONE has no effect.
REQ-022 SHALL use the SHA-256 IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 (a..h).
REQ-023 SHALL use the SHA-224 IV c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4 (a..h).

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, t=0, S=C=W=0, h_o=0, out_valid_o=0 and in_ready_o=1, irrespective of clk.
REQ-025 SHALL, on reset asserted mid-BUSY or in DONE, abort the block with no output handshake; the first accept after release starts a fresh block.

Configuration
REQ-026 SHALL provide macro SHA256_UNROLL2_EN, all code under SLOTH_SHA256. When defined, it chains two round instances per cycle (rounds t and t+1), t steps by 2, and BUSY lasts 32 cycles. When undefined, one round per cycle, 64 cycles. Results are bit-identical in both builds.

Verification
REQ-027 SHALL test SHA-256 "abc": init_i=1, m_i = single padded block (W0=61626380, W15=00000018, others 0) -> h_o a..h = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid_o at cycle 64 (32 with unroll).
REQ-028 SHALL test the empty message: W0=80000000, others 0 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-029 SHALL test SHA224=1 with the "abc" block -> a..g = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
REQ-030 SHALL test two-block chaining, 56-byte "abcdbcdecdefdefg...nopq": block 1 init_i=1, block 2 init_i=0 with h_i = block-1 h_o -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-031 SHALL test back-pressure: out_ready_i=0 for 10 cycles in DONE with in_valid_i=1 -> in_ready_o=0, h_o stable; out_ready_i=1 -> IDLE next cycle.
REQ-032 SHALL test reset at BUSY cycle 20: rst_n pulsed low -> h_o=0, IDLE immediately; re-run "abc" gives the REQ-027 result.
